// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : shared encodings for the SDRAM two-port arbiter
// Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_t;

   localparam int PORT_VIDEO = 0;
   localparam int PORT_CPU   = 1;

   localparam logic [1:0] GRANT_NONE  = 2'b00;
   localparam logic [1:0] GRANT_VIDEO = 2'b01;
   localparam logic [1:0] GRANT_CPU   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`default_nettype none
// ============================================================================
// mem_arb_grant : fixed-priority select with a port 1 anti-starvation streak
// Revision      : 1.0  initial release
// ============================================================================
module mem_arb_grant
   import mem_arb_pkg::*;
#(
   parameter int MAX_STREAK = 4
) (
   input  logic       command_clk,
   input  logic       nreset,
   input  logic       p0_req,
   input  logic       p1_req,
   input  logic       arbitrate,
   output logic [1:0] winner
);

   localparam int STREAK_W = $clog2(MAX_STREAK + 1);
   localparam logic [STREAK_W-1:0] c_streak_max = STREAK_W'(MAX_STREAK);

   logic [STREAK_W-1:0] r_streak;
   logic                w_starved;

   assign w_starved = (r_streak == c_streak_max);

   always_comb begin
      winner = GRANT_NONE;
      if (p1_req && (!p0_req || w_starved)) begin
         winner = GRANT_CPU;
      end else if (p0_req) begin
         winner = GRANT_VIDEO;
      end
   end

   // Streak only measures port 0 wins while port 1 is actually waiting.
   always_ff @(posedge command_clk) begin
      if (nreset) begin
         r_streak <= '0;
      end else if (!p1_req) begin
         r_streak <= '0;
      end else if (arbitrate) begin
         if (winner[PORT_CPU]) begin
            r_streak <= '0;
         end else if (winner[PORT_VIDEO] && !w_starved) begin
            r_streak <= r_streak + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares the SDRAM controller between video (port 0) and CPU
//               (port 1); holds the bundle until completion or timeout.
// Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W         = 24,
   parameter int DATA_W         = 2048,
   parameter int SIZE_W         = 9,
   parameter int MAX_STREAK     = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic              command_clk,
   input  logic              nreset,
   input  logic              p0_req,
   input  logic              p0_we_n,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [SIZE_W-1:0] p0_size,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic              p0_err,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we_n,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [SIZE_W-1:0] p1_size,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic              p1_err,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [1:0]        grant,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [SIZE_W-1:0] mem_size_r,
   output logic [SIZE_W-1:0] mem_size_w,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we_n,
   output logic              mem_request,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_data_ready,
   input  logic              mem_save_ready,
   input  logic              mem_busy
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] c_timeout_last = TO_W'(TIMEOUT_CYCLES - 1);

   arb_state_t      r_state, w_state_nxt;
   logic [1:0]      r_grant, w_grant_nxt;
   logic            r_mem_request, w_req_nxt;
   logic [TO_W-1:0] r_cnt, w_cnt_nxt;
   logic [1:0]      r_ack, w_ack_nxt;
   logic [1:0]      r_err, w_err_nxt;
   logic [1:0]      w_capture;
   logic            w_arbitrate;
   logic [1:0]      w_winner;
   logic            w_sel_cpu;
   logic            w_ready;
   logic [DATA_W-1:0] r_p0_rdata, r_p1_rdata;

   mem_arb_grant #(
      .MAX_STREAK (MAX_STREAK)
   ) u_grant (
      .command_clk (command_clk),
      .nreset      (nreset),
      .p0_req      (p0_req),
      .p1_req      (p1_req),
      .arbitrate   (w_arbitrate),
      .winner      (w_winner)
   );

   // Bundle follows the owner; with no owner it shows port 0 inputs.
   assign w_sel_cpu  = r_grant[PORT_CPU];
   assign mem_addr   = w_sel_cpu ? p1_addr  : p0_addr;
   assign mem_size_r = w_sel_cpu ? p1_size  : p0_size;
   assign mem_size_w = w_sel_cpu ? p1_size  : p0_size;
   assign mem_wdata  = w_sel_cpu ? p1_wdata : p0_wdata;
   assign mem_we_n   = w_sel_cpu ? p1_we_n  : p0_we_n;
   assign w_ready    = mem_we_n ? mem_data_ready : mem_save_ready;

   always_ff @(posedge command_clk) begin
      if (nreset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_req_nxt   = r_mem_request;
      w_cnt_nxt   = r_cnt;
      w_ack_nxt   = 2'b00;
      w_err_nxt   = 2'b00;
      w_capture   = 2'b00;
      w_arbitrate = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!mem_busy && (p0_req || p1_req)) begin
               w_arbitrate = 1'b1;
               w_grant_nxt = w_winner;
               w_req_nxt   = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (w_ready) begin
               w_ack_nxt   = r_grant;
               w_capture   = mem_we_n ? r_grant : 2'b00;
               w_req_nxt   = 1'b0;
               w_grant_nxt = GRANT_NONE;
               w_state_nxt = ST_RELEASE;
            end else if (r_cnt == c_timeout_last) begin
               w_ack_nxt   = r_grant;
               w_err_nxt   = r_grant;
               w_req_nxt   = 1'b0;
               w_grant_nxt = GRANT_NONE;
               w_state_nxt = ST_RELEASE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_RELEASE: begin
            w_grant_nxt = GRANT_NONE;
            if (!mem_busy) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_grant_nxt = GRANT_NONE;
            w_req_nxt   = 1'b0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge command_clk) begin
      if (nreset) begin
         r_grant       <= GRANT_NONE;
         r_mem_request <= 1'b0;
         r_cnt         <= '0;
         r_ack         <= 2'b00;
         r_err         <= 2'b00;
         r_p0_rdata    <= '0;
         r_p1_rdata    <= '0;
      end else begin
         r_grant       <= w_grant_nxt;
         r_mem_request <= w_req_nxt;
         r_cnt         <= w_cnt_nxt;
         r_ack         <= w_ack_nxt;
         r_err         <= w_err_nxt;
         if (w_capture[PORT_VIDEO]) r_p0_rdata <= mem_rdata;
         if (w_capture[PORT_CPU])   r_p1_rdata <= mem_rdata;
      end
   end

   assign grant       = r_grant;
   assign mem_request = r_mem_request;
   assign p0_ack      = r_ack[PORT_VIDEO];
   assign p1_ack      = r_ack[PORT_CPU];
   assign p0_err      = r_err[PORT_VIDEO];
   assign p1_err      = r_err[PORT_CPU];
   assign p0_rdata    = r_p0_rdata;
   assign p1_rdata    = r_p1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Revision       : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 2048;
   localparam int SIZE_W = 9;

   logic              command_clk;
   logic              nreset;
   logic              p0_req, p0_we_n, p1_req, p1_we_n;
   logic [ADDR_W-1:0] p0_addr, p1_addr;
   logic [SIZE_W-1:0] p0_size, p1_size;
   logic [DATA_W-1:0] p0_wdata, p1_wdata;
   logic              p0_ack, p0_err, p1_ack, p1_err;
   logic [DATA_W-1:0] p0_rdata, p1_rdata;
   logic [1:0]        grant;
   logic [ADDR_W-1:0] mem_addr;
   logic [SIZE_W-1:0] mem_size_r, mem_size_w;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              mem_we_n, mem_request;
   logic              mem_data_ready, mem_save_ready, mem_busy;

   int vectors;
   int miscompares;
   logic [15:0] exp_p0_word;
   logic [15:0] exp_p1_word;

   mem_arbiter #(
      .ADDR_W         (ADDR_W),
      .DATA_W         (DATA_W),
      .SIZE_W         (SIZE_W),
      .MAX_STREAK     (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .command_clk    (command_clk),
      .nreset         (nreset),
      .p0_req         (p0_req),
      .p0_we_n        (p0_we_n),
      .p0_addr        (p0_addr),
      .p0_size        (p0_size),
      .p0_wdata       (p0_wdata),
      .p0_ack         (p0_ack),
      .p0_err         (p0_err),
      .p0_rdata       (p0_rdata),
      .p1_req         (p1_req),
      .p1_we_n        (p1_we_n),
      .p1_addr        (p1_addr),
      .p1_size        (p1_size),
      .p1_wdata       (p1_wdata),
      .p1_ack         (p1_ack),
      .p1_err         (p1_err),
      .p1_rdata       (p1_rdata),
      .grant          (grant),
      .mem_addr       (mem_addr),
      .mem_size_r     (mem_size_r),
      .mem_size_w     (mem_size_w),
      .mem_wdata      (mem_wdata),
      .mem_we_n       (mem_we_n),
      .mem_request    (mem_request),
      .mem_rdata      (mem_rdata),
      .mem_data_ready (mem_data_ready),
      .mem_save_ready (mem_save_ready),
      .mem_busy       (mem_busy)
   );

   initial command_clk = 1'b0;
   always #5 command_clk = ~command_clk;

   task automatic tick();
      @(posedge command_clk);
      #1;
   endtask

   task automatic settle();
      p0_req = 1'b0;
      p1_req = 1'b0;
      mem_data_ready = 1'b0;
      mem_save_ready = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      nreset = 1'b1;
      repeat (2) tick();
      vectors++;
      if ({mem_request, p0_ack, p1_ack, p0_err, p1_err, grant} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b expected 0000000",
                  {mem_request, p0_ack, p1_ack, p0_err, p1_err, grant});
      end
      vectors++;
      if (p0_rdata !== '0 || p1_rdata !== '0) begin
         miscompares++;
         $display("FAIL reset_rdata: got p0=%h p1=%h expected 0", p0_rdata[15:0], p1_rdata[15:0]);
      end
      nreset = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      p1_we_n = 1'b1;
      p1_addr = 24'h012345;
      p1_size = 9'd1;
      p1_req  = 1'b1;
      tick();
      vectors++;
      if (grant !== 2'b10 || mem_request !== 1'b1) begin
         miscompares++;
         $display("FAIL read_issue: got grant=%b req=%b expected 10/1", grant, mem_request);
      end
      vectors++;
      if (mem_addr !== 24'h012345 || mem_size_r !== 9'd1 || mem_we_n !== 1'b1) begin
         miscompares++;
         $display("FAIL read_bundle: got addr=%h size=%0d we_n=%b expected 012345/1/1",
                  mem_addr, mem_size_r, mem_we_n);
      end
      repeat (5) begin
         tick();
         vectors++;
         if (p1_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL read_early_ack: got %b expected 0", p1_ack);
         end
      end
      mem_rdata = '0;
      mem_rdata[15:0] = 16'hBEEF;
      mem_data_ready = 1'b1;
      tick();
      exp_p1_word = 16'hBEEF;
      vectors++;
      if (p1_ack !== 1'b1 || p1_err !== 1'b0 || mem_request !== 1'b0) begin
         miscompares++;
         $display("FAIL read_ack: got ack=%b err=%b req=%b expected 1/0/0", p1_ack, p1_err, mem_request);
      end
      vectors++;
      if (p1_rdata[15:0] !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL read_data: got %h expected beef", p1_rdata[15:0]);
      end
      mem_data_ready = 1'b0;
      p1_req = 1'b0;
      tick();
      vectors++;
      if (p1_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL read_ack_width: got %b expected 0", p1_ack);
      end
      settle();
   endtask

   task automatic test_simultaneous();
      p0_we_n = 1'b1;
      p0_addr = 24'h000A00;
      p0_size = 9'd128;
      p1_we_n = 1'b1;
      p1_addr = 24'h000B00;
      p1_size = 9'd2;
      p0_req = 1'b1;
      p1_req = 1'b1;
      tick();
      vectors++;
      if (grant !== 2'b01 || mem_addr !== 24'h000A00 || mem_size_r !== 9'd128) begin
         miscompares++;
         $display("FAIL simul_first: got grant=%b addr=%h size=%0d expected 01/000a00/128",
                  grant, mem_addr, mem_size_r);
      end
      repeat (2) tick();
      mem_rdata[15:0] = 16'h1111;
      mem_data_ready = 1'b1;
      tick();
      exp_p0_word = 16'h1111;
      vectors++;
      if (p0_ack !== 1'b1 || p1_ack !== 1'b0 || p0_rdata[15:0] !== 16'h1111) begin
         miscompares++;
         $display("FAIL simul_p0_ack: got ack0=%b ack1=%b data=%h expected 1/0/1111",
                  p0_ack, p1_ack, p0_rdata[15:0]);
      end
      mem_data_ready = 1'b0;
      p0_req = 1'b0;
      tick();
      vectors++;
      if (grant !== 2'b00) begin
         miscompares++;
         $display("FAIL simul_gap: got grant=%b expected 00", grant);
      end
      tick();
      vectors++;
      if (grant !== 2'b10 || mem_addr !== 24'h000B00) begin
         miscompares++;
         $display("FAIL simul_second: got grant=%b addr=%h expected 10/000b00", grant, mem_addr);
      end
      mem_rdata[15:0] = 16'h2222;
      mem_data_ready = 1'b1;
      tick();
      exp_p1_word = 16'h2222;
      vectors++;
      if (p1_ack !== 1'b1 || p1_rdata[15:0] !== 16'h2222 || p0_rdata[15:0] !== 16'h1111) begin
         miscompares++;
         $display("FAIL simul_p1_ack: got ack=%b d1=%h d0=%h expected 1/2222/1111",
                  p1_ack, p1_rdata[15:0], p0_rdata[15:0]);
      end
      settle();
   endtask

   task automatic test_starvation();
      logic [1:0] exp_grant [6];
      logic       got;
      exp_grant = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
      p0_we_n = 1'b1;
      p1_we_n = 1'b1;
      p0_req = 1'b1;
      p1_req = 1'b1;
      for (int g = 0; g < 6; g++) begin
         got = 1'b0;
         for (int t = 0; t < 8 && !got; t++) begin
            tick();
            if (grant !== 2'b00) got = 1'b1;
         end
         vectors++;
         if (grant !== exp_grant[g]) begin
            miscompares++;
            $display("FAIL starve_grant%0d: got %b expected %b", g, grant, exp_grant[g]);
         end
         mem_rdata[15:0] = 16'hA000 + 16'(g);
         mem_data_ready = 1'b1;
         tick();
         mem_data_ready = 1'b0;
         if (exp_grant[g] == 2'b01) exp_p0_word = 16'hA000 + 16'(g);
         else                       exp_p1_word = 16'hA000 + 16'(g);
         vectors++;
         if ({p1_ack, p0_ack} !== exp_grant[g]) begin
            miscompares++;
            $display("FAIL starve_ack%0d: got %b expected %b", g, {p1_ack, p0_ack}, exp_grant[g]);
         end
      end
      vectors++;
      if (p0_rdata[15:0] !== exp_p0_word || p1_rdata[15:0] !== exp_p1_word) begin
         miscompares++;
         $display("FAIL starve_data: got d0=%h d1=%h expected %h/%h",
                  p0_rdata[15:0], p1_rdata[15:0], exp_p0_word, exp_p1_word);
      end
      settle();
   endtask

   task automatic test_write();
      p1_we_n = 1'b0;
      p1_addr = 24'h000100;
      p1_size = 9'd1;
      p1_wdata = '0;
      p1_wdata[15:0] = 16'h55AA;
      p1_req = 1'b1;
      tick();
      vectors++;
      if (grant !== 2'b10 || mem_we_n !== 1'b0 || mem_wdata[15:0] !== 16'h55AA || mem_size_w !== 9'd1) begin
         miscompares++;
         $display("FAIL write_bundle: got grant=%b we_n=%b wdata=%h size=%0d expected 10/0/55aa/1",
                  grant, mem_we_n, mem_wdata[15:0], mem_size_w);
      end
      tick();
      mem_rdata[15:0] = 16'hDEAD;
      mem_data_ready = 1'b1;
      tick();
      mem_data_ready = 1'b0;
      vectors++;
      if (p1_ack !== 1'b0 || mem_request !== 1'b1) begin
         miscompares++;
         $display("FAIL write_wrong_ready: got ack=%b req=%b expected 0/1", p1_ack, mem_request);
      end
      tick();
      mem_save_ready = 1'b1;
      tick();
      mem_save_ready = 1'b0;
      vectors++;
      if (p1_ack !== 1'b1 || p1_err !== 1'b0 || mem_request !== 1'b0) begin
         miscompares++;
         $display("FAIL write_ack: got ack=%b err=%b req=%b expected 1/0/0", p1_ack, p1_err, mem_request);
      end
      vectors++;
      if (p1_rdata[15:0] !== exp_p1_word) begin
         miscompares++;
         $display("FAIL write_rdata_hold: got %h expected %h", p1_rdata[15:0], exp_p1_word);
      end
      p1_we_n = 1'b1;
      settle();
   endtask

   task automatic test_timeout();
      p0_we_n = 1'b1;
      p0_addr = 24'h00C000;
      p0_req = 1'b1;
      tick();
      vectors++;
      if (grant !== 2'b01 || mem_request !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_issue: got grant=%b req=%b expected 01/1", grant, mem_request);
      end
      for (int c = 1; c < 16; c++) begin
         tick();
         vectors++;
         if (p0_ack !== 1'b0 || mem_request !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_early%0d: got ack=%b req=%b expected 0/1", c, p0_ack, mem_request);
         end
      end
      tick();
      vectors++;
      if (p0_ack !== 1'b1 || p0_err !== 1'b1 || mem_request !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_abort: got ack=%b err=%b req=%b expected 1/1/0", p0_ack, p0_err, mem_request);
      end
      vectors++;
      if (p0_rdata[15:0] !== exp_p0_word) begin
         miscompares++;
         $display("FAIL timeout_rdata: got %h expected %h", p0_rdata[15:0], exp_p0_word);
      end
      p0_req = 1'b0;
      tick();
      vectors++;
      if (p0_ack !== 1'b0 || p0_err !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_pulse: got ack=%b err=%b expected 0/0", p0_ack, p0_err);
      end
      settle();
   endtask

   task automatic test_reset_in_issue();
      p1_we_n = 1'b1;
      p1_addr = 24'h000200;
      p1_req = 1'b1;
      tick();
      tick();
      nreset = 1'b1;
      mem_busy = 1'b1;
      mem_rdata[15:0] = 16'h7777;
      mem_data_ready = 1'b1;
      tick();
      vectors++;
      if ({mem_request, p0_ack, p1_ack, p0_err, p1_err, grant} !== 7'b0 ||
          p0_rdata !== '0 || p1_rdata !== '0) begin
         miscompares++;
         $display("FAIL rst_issue_outputs: got %b d1=%h expected 0000000/0",
                  {mem_request, p0_ack, p1_ack, p0_err, p1_err, grant}, p1_rdata[15:0]);
      end
      nreset = 1'b0;
      mem_data_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         vectors++;
         if (grant !== 2'b00 || mem_request !== 1'b0 || p1_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_busy_hold%0d: got grant=%b req=%b ack=%b expected 00/0/0",
                     c, grant, mem_request, p1_ack);
         end
      end
      mem_busy = 1'b0;
      tick();
      vectors++;
      if (grant !== 2'b10 || mem_request !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_regrant: got grant=%b req=%b expected 10/1", grant, mem_request);
      end
      mem_rdata[15:0] = 16'h3333;
      mem_data_ready = 1'b1;
      tick();
      vectors++;
      if (p1_ack !== 1'b1 || p1_rdata[15:0] !== 16'h3333) begin
         miscompares++;
         $display("FAIL rst_complete: got ack=%b data=%h expected 1/3333", p1_ack, p1_rdata[15:0]);
      end
      settle();
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      exp_p0_word = 16'h0000;
      exp_p1_word = 16'h0000;
      nreset = 1'b1;
      p0_req = 1'b0;
      p0_we_n = 1'b1;
      p0_addr = '0;
      p0_size = 9'd1;
      p0_wdata = '0;
      p1_req = 1'b0;
      p1_we_n = 1'b1;
      p1_addr = '0;
      p1_size = 9'd1;
      p1_wdata = '0;
      mem_rdata = '0;
      mem_data_ready = 1'b0;
      mem_save_ready = 1'b0;
      mem_busy = 1'b0;

      test_reset();
      test_single_read();
      test_simultaneous();
      test_starvation();
      test_write();
      test_timeout();
      test_reset_in_issue();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the SDRAM memory_controller between the video scanline fetcher (port 0, burst reads) and a general read/write client (port 1). The arbiter selects one requester, drives the controller's request/address/size/data bundle, holds it until the controller reports completion, and returns data plus a one-cycle acknowledge to the winner. Port 0 has fixed priority; a streak counter bounds port 1 starvation, and a timeout bounds a hung transaction. It runs in the controller's command clock domain.

## Interface
- ADDR_W, 24, address width (bank/row/column as the controller decodes it)
- DATA_W, 2048, read/write data bundle width (128 x 16-bit words)
- SIZE_W, 9, transfer size width in words
- MAX_STREAK, 4, consecutive port 0 grants allowed while port 1 waits
- TIMEOUT_CYCLES, 65535, maximum cycles in ISSUE before abort
- command_clk  in  1  clock, same edge the controller's command logic uses
- nreset  in  1  reset nreset, synchronous, active-high
- pN_req  in  1  (N=0,1) level request, held until pN_ack
- pN_we_n  in  1  1 = read, 0 = write (port 0 ties to 1)
- pN_addr  in  ADDR_W  word address
- pN_size  in  SIZE_W  words to transfer, 1..128
- pN_wdata  in  DATA_W  write data, word 0 in bits [15:0]
- pN_ack  out  1  one-cycle completion pulse
- pN_err  out  1  one-cycle, coincident with pN_ack, on timeout
- pN_rdata  out  DATA_W  read data, registered at ack
- grant  out  2  one-hot current owner, 00 when idle
- mem_addr, mem_size_r, mem_size_w, mem_wdata, mem_we_n  out  to controller addr, data_read_size, data_write_size, data_write, n_write_enable
- mem_request  out  1  to controller request
- mem_rdata  in  DATA_W  from controller data_read
- mem_data_ready, mem_save_ready, mem_busy  in  1  from controller

## Operation
- States: IDLE, ISSUE, RELEASE (2-bit encoding).
- IDLE: if mem_busy=0 and any pN_req: pick winner, set grant, mem_request<=1, go ISSUE. mem_busy=1 (including controller init) -> stay.
- Selection: port 0 if p0_req, unless streak==MAX_STREAK and p1_req, then port 1. Single requester wins outright.
- Streak: +1 on each port 0 grant while p1_req=1; cleared on port 1 grant or whenever p1_req=0; saturates at MAX_STREAK.
- mem_* bundle muxed from granted port inputs; mem_size_r and mem_size_w both driven from pN_size; requester holds inputs stable until ack. Idle: bundle = port 0 inputs, mem_request=0.
- ISSUE: on mem_data_ready (read) or mem_save_ready (write): reads capture mem_rdata into pN_rdata; pN_ack=1 one cycle; mem_request<=0; go RELEASE.
- Timeout: cycle counter in ISSUE; at TIMEOUT_CYCLES with no ready, pN_ack=pN_err=1, pN_rdata unchanged, mem_request<=0, go RELEASE.
- RELEASE: grant<=00; return IDLE when mem_busy=0 (minimum one cycle in RELEASE).
- Ready pulses outside ISSUE, or of the wrong kind, are ignored.
- pN_req dropped before ack: transaction still completes; ack is issued regardless.
- Reset: all outputs 0 (mem_request, pN_ack, pN_err, grant, pN_rdata), streak 0, counter 0, state IDLE; reset during ISSUE aborts without ack.

## Timing
- mem_request, grant, pN_ack, pN_err, pN_rdata registered.
- Request edge: pN_req sampled at edge k in IDLE -> mem_request=1 after edge k.
- Ack: ready sampled at edge m -> pN_ack high for cycle after m; mem_request low same cycle.
- Minimum turnaround: ack to next grant 2 cycles (RELEASE + IDLE) if mem_busy=0.
- Back-to-back same-port requests allowed; requester sees ack, may hold pN_req for the next transfer.
- Timeout counter width clog2(TIMEOUT_CYCLES+1); abort exactly TIMEOUT_CYCLES cycles after entering ISSUE.

## Structure
- Package mem_arb_pkg: state encoding (ST_IDLE, ST_ISSUE, ST_RELEASE), port indices PORT_VIDEO=0, PORT_CPU=1, grant one-hot constants.
- Sub-module mem_arb_grant: priority select plus streak counter; inputs p0_req, p1_req, arbitrate strobe; output one-hot winner. Top holds FSM, timeout, mux, rdata registers.

## Test plan
- Single read: p1 read addr 24'h012345 size 1, model returns data_ready after 6 cycles with word 16'hBEEF -> p1_ack one cycle, p1_rdata[15:0]=16'hBEEF, p1_err=0.
- Simultaneous requests in IDLE -> grant=01 first, p0 acked, then grant=10 without p1 re-request.
- Starvation: p0_req held continuously, p1_req held -> exactly 4 port 0 grants, then one port 1 grant, streak cleared.
- Write: p1 we_n=0 size 1 wdata 16'h55AA -> mem_we_n=0, mem_wdata[15:0]=16'h55AA; p1_ack on save_ready; data_ready pulse ignored.
- Timeout (TIMEOUT_CYCLES=16): model never readies -> p0_ack=p0_err=1 at 16 cycles, p0_rdata unchanged, mem_request=0.
- Reset in ISSUE: nreset=1 mid-transfer -> next cycle all outputs 0, no ack; with mem_busy=1 held, no new grant until it falls.
